// File: rtl/communication_receive.sv
// Serial byte receiver: synchronizes sd/freq/rec_en, shifts bits MSB first, flags aborts and stalls.
// Optional trailing even-parity bit when COMM_RX_PARITY_EN is defined.
module communication_receive #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              sd,
  input  logic              freq,
  input  logic              rec_en,
  output logic [DATA_W-1:0] rec_data,
  output logic              rec_valid,
  output logic              frame_err,
  output logic              busy,
  output logic              parity_err
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC);
  localparam int CNT_W = $clog2(DATA_W + 2);
`ifdef COMM_RX_PARITY_EN
  localparam int NBITS = DATA_W + 1;
`else
  localparam int NBITS = DATA_W;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, WAIT_END} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sd_sync_q, sd_sync_d;
  logic [SYNC_STAGES-1:0] freq_sync_q, freq_sync_d;
  logic [SYNC_STAGES-1:0] en_sync_q, en_sync_d;
  logic                   freq_prev_q, freq_prev_d;
  logic                   en_prev_q, en_prev_d;
  logic                   freq_rise_q, freq_rise_d;
  logic                   en_rise_q, en_rise_d;
  logic                   en_fall_q, en_fall_d;
  logic                   sd_bit_q, sd_bit_d;
  logic [DATA_W-1:0]      shreg_q, shreg_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [DATA_W-1:0]      rec_data_q, rec_data_d;
  logic                   rec_valid_q, rec_valid_d;
  logic                   frame_err_q, frame_err_d;
`ifdef COMM_RX_PARITY_EN
  logic                   par_q, par_d;
  logic                   parity_err_q, parity_err_d;
`endif

  logic freq_s, en_s;
  assign freq_s = freq_sync_q[SYNC_STAGES-1];
  assign en_s   = en_sync_q[SYNC_STAGES-1];

  // Edge flags are registered, so each one lines up with the sd bit sampled beside it.
  always_comb begin
    sd_sync_d   = {sd_sync_q[SYNC_STAGES-2:0], sd};
    freq_sync_d = {freq_sync_q[SYNC_STAGES-2:0], freq};
    en_sync_d   = {en_sync_q[SYNC_STAGES-2:0], rec_en};
    freq_prev_d = freq_s;
    en_prev_d   = en_s;
    freq_rise_d = freq_s & ~freq_prev_q;
    en_rise_d   = en_s & ~en_prev_q;
    en_fall_d   = ~en_s & en_prev_q;
    sd_bit_d    = sd_sync_q[SYNC_STAGES-1];
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    timer_d     = timer_q;
    rec_data_d  = rec_data_q;
    rec_valid_d = 1'b0;
    frame_err_d = 1'b0;
`ifdef COMM_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (en_rise_q) begin
          state_d   = SHIFT;
          shreg_d   = '0;
          bit_cnt_d = '0;
          timer_d   = '0;
`ifdef COMM_RX_PARITY_EN
          par_d     = 1'b0;
`endif
        end
      end
      SHIFT: begin
        if (en_fall_q) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else if (freq_rise_q) begin
          // The parity bit only feeds the checksum, never the data register.
          if (bit_cnt_q < CNT_W'(DATA_W))
            shreg_d = {shreg_q[DATA_W-2:0], sd_bit_q};
`ifdef COMM_RX_PARITY_EN
          par_d     = par_q ^ sd_bit_q;
`endif
          bit_cnt_d = bit_cnt_q + 1'b1;
          timer_d   = '0;
          if (bit_cnt_q == CNT_W'(NBITS - 1))
            state_d = DONE;
        end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DONE: begin
`ifdef COMM_RX_PARITY_EN
        if (!par_q) begin
          rec_data_d  = shreg_q;
          rec_valid_d = 1'b1;
        end else begin
          parity_err_d = 1'b1;
        end
`else
        rec_data_d  = shreg_q;
        rec_valid_d = 1'b1;
`endif
        state_d = WAIT_END;
      end
      WAIT_END: begin
        if (!en_s)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q     <= IDLE;
      sd_sync_q   <= '0;
      freq_sync_q <= '0;
      en_sync_q   <= '0;
      freq_prev_q <= 1'b0;
      en_prev_q   <= 1'b0;
      freq_rise_q <= 1'b0;
      en_rise_q   <= 1'b0;
      en_fall_q   <= 1'b0;
      sd_bit_q    <= 1'b0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      timer_q     <= '0;
      rec_data_q  <= '0;
      rec_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef COMM_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sd_sync_q   <= sd_sync_d;
      freq_sync_q <= freq_sync_d;
      en_sync_q   <= en_sync_d;
      freq_prev_q <= freq_prev_d;
      en_prev_q   <= en_prev_d;
      freq_rise_q <= freq_rise_d;
      en_rise_q   <= en_rise_d;
      en_fall_q   <= en_fall_d;
      sd_bit_q    <= sd_bit_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      timer_q     <= timer_d;
      rec_data_q  <= rec_data_d;
      rec_valid_q <= rec_valid_d;
      frame_err_q <= frame_err_d;
`ifdef COMM_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rec_data  = rec_data_q;
  assign rec_valid = rec_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);
`ifdef COMM_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_communication_receive.sv
// Scoreboard bench for communication_receive: directed frames, abort, timeout, reset and parity cases.
module tb_communication_receive;
  localparam int DW = 8;
  localparam int SS = 2;
  localparam int TO = 1024;
`ifdef COMM_RX_PARITY_EN
  localparam int NB = DW + 1;
`else
  localparam int NB = DW;
`endif
  localparam int K_VALID = 0;
  localparam int K_FERR  = 1;
  localparam int K_PERR  = 2;

  logic clk1 = 1'b0, rst = 1'b1, sd = 1'b0, freq = 1'b0, rec_en = 1'b0;
  logic [DW-1:0] rec_data;
  logic rec_valid, frame_err, busy, parity_err;

  communication_receive #(.DATA_W(DW), .SYNC_STAGES(SS), .TIMEOUT_CYC(TO)) dut (
    .clk1(clk1), .rst(rst), .sd(sd), .freq(freq), .rec_en(rec_en),
    .rec_data(rec_data), .rec_valid(rec_valid), .frame_err(frame_err),
    .busy(busy), .parity_err(parity_err)
  );

  always #5 clk1 = ~clk1;

  int cyc = 0;
  always @(posedge clk1) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          kind;
    logic [7:0]  data;
    int          at;
  } exp_t;
  exp_t sb[$];

  logic [7:0] last_good = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk1);
  endtask

  task automatic push(input int kind, input logic [7:0] data, input int at);
    exp_t e;
    e.kind = kind; e.data = data; e.at = at;
    sb.push_back(e);
  endtask

  // Send nb bits of w, MSB first; the event for the last bit is queued the moment it is driven.
  task automatic send_bits(input logic [8:0] w, input int nb, input int kind,
                           input logic [7:0] d, output int last_c);
    last_c = 0;
    for (int i = nb - 1; i >= 0; i--) begin
      sd = w[i];
      freq = 1'b1;
      last_c = cyc;
      if (i == 0 && kind >= 0) push(kind, d, last_c + 1 + SS + 2);
      tick(4);
      freq = 1'b0;
      tick(4);
    end
  endtask

  task automatic frame(input logic [8:0] w, input int nb, input int kind, input logic [7:0] d);
    int lc;
    rec_en = 1'b1;
    tick(4);
    send_bits(w, nb, kind, d, lc);
    tick(2);
    check("busy_wait_end", busy, 1);
    rec_en = 1'b0;
    tick(3);
  endtask

  function automatic logic [8:0] word(input logic [7:0] d, input logic pbit);
`ifdef COMM_RX_PARITY_EN
    return {d, pbit};
`else
    return {1'b0, d} ^ {8'h00, pbit & 1'b0};
`endif
  endfunction

  always begin
    int kind;
    exp_t e;
    @(posedge clk1);
    #2;
    if (rec_valid || frame_err || parity_err) begin
      kind = rec_valid ? K_VALID : (frame_err ? K_FERR : K_PERR);
      check("valid_err_exclusive", {31'd0, rec_valid & frame_err}, 0);
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", kind, cyc);
      end else begin
        e = sb.pop_front();
        check("event_kind", kind, e.kind);
        if (e.kind != K_FERR) check("rec_data", {24'd0, rec_data}, {24'd0, e.data});
        if (e.at >= 0) check("event_cycle", cyc, e.at);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lc;
    // Reset hold with toggling inputs
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sd = i[0]; freq = i[1]; rec_en = i[2];
      tick(1);
      check("reset_outputs", {rec_data, rec_valid, frame_err, busy, parity_err}, 0);
    end
    sd = 1'b0; freq = 1'b0; rec_en = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(4);
    check("idle_after_reset", busy, 0);

    // Nominal byte 8'hAE
    last_good = 8'hAE;
    frame(word(8'hAE, 1'b0), NB, K_VALID, 8'hAE);
    tick(2);
    check("busy_after_frame", busy, 0);
    check("rec_data_hold", {24'd0, rec_data}, 32'hAE);

    // Abort after 5 bits
    rec_en = 1'b1;
    tick(4);
    send_bits(9'b1_0101, 5, -1, 8'h00, lc);
    push(K_FERR, 8'h00, -1);
    rec_en = 1'b0;
    tick(8);
    check("abort_keeps_data", {24'd0, rec_data}, 32'hAE);
    check("abort_idle", busy, 0);

    // Timeout after 3 bits, then a good 8'h5A
    rec_en = 1'b1;
    tick(4);
    send_bits(9'b101, 3, -1, 8'h00, lc);
    push(K_FERR, 8'h00, lc + 1 + SS + 1 + TO);
    tick(TO + 20);
    check("timeout_idle", busy, 0);
    rec_en = 1'b0;
    tick(5);
    last_good = 8'h5A;
    frame(word(8'h5A, 1'b0), NB, K_VALID, 8'h5A);
    tick(2);

    // Back-to-back frames, 3 idle cycles between
    frame(word(8'hFF, 1'b0), NB, K_VALID, 8'hFF);
    frame(word(8'h00, 1'b0), NB, K_VALID, 8'h00);
    last_good = 8'h00;
    tick(3);
    check("b2b_data", {24'd0, rec_data}, 32'h00);

    // Reset mid-frame: no event, data cleared
    frame(word(8'h3C, 1'b0), NB, K_VALID, 8'h3C);
    tick(2);
    rec_en = 1'b1;
    tick(4);
    send_bits(9'b110, 3, -1, 8'h00, lc);
    rst = 1'b1;
    rec_en = 1'b0;
    tick(3);
    check("midreset_data", {24'd0, rec_data}, 0);
    rst = 1'b0;
    tick(6);
    check("midreset_idle", busy, 0);
    last_good = 8'h00;

`ifdef COMM_RX_PARITY_EN
    frame({8'hAE, 1'b1}, NB, K_VALID, 8'hAE);
    tick(2);
    frame({8'hAE, 1'b0}, NB, K_PERR, 8'hAE);
    tick(2);
    check("parity_keeps_data", {24'd0, rec_data}, 32'hAE);
`endif

    tick(10);
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
